if_id_hazard_reg: RTL

//   IF/ID pipeline register with the ID-stage hazard stall controller. Feeds IF_ID_rs/rt to
//   the ID forwarding unit. Detects load-use and ID-resolved branch/jr hazards.
//   On a hazard it stalls PC and IF/ID and injects an ID/EX bubble. Flushes IF/ID on a taken

---
 rtl/if_id_hazard_reg.sv | 122 ++++++++++++
 1 files changed

// File: rtl/if_id_hazard_reg.sv
// IF/ID pipeline register with the ID-stage hazard stall controller:
// load-use and ID-resolved branch/jr stalls, taken-branch/jump flush, and a saturating stall counter.
module if_id_hazard_reg #(
    parameter int                DATA_W = 32,
    parameter int                CNT_W  = 16,
    parameter logic [DATA_W-1:0] NOP    = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] IF_Instruction,
    input  logic [DATA_W-1:0] IF_PC_plus4,
    input  logic              ID_UsesRs,
    input  logic              ID_UsesRt,
    input  logic              ID_IsBranchOrJr,
    input  logic              ID_Branch_taken,
    input  logic              ID_Jump,
    input  logic              ID_EX_RegWrite,
    input  logic              ID_EX_MemRead,
    input  logic [4:0]        ID_EX_Write_register,
    input  logic              EX_MEM_MemRead,
    input  logic [4:0]        EX_MEM_Write_register,
    output logic [DATA_W-1:0] IF_ID_Instruction,
    output logic [DATA_W-1:0] IF_ID_PC_plus4,
    output logic [4:0]        IF_ID_rs,
    output logic [4:0]        IF_ID_rt,
    output logic              IF_ID_valid,
    output logic              PC_Write,
    output logic              ID_EX_Bubble,
    output logic              stall_active,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

    state_t state;
    logic   remaining;
    logic   need_rs, need_rt, hx, hm, need1, need2, flush;

    function automatic logic dest_match(input logic [4:0] d, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic use_rs,
                                        input logic use_rt);
        return ((d == rs) && use_rs) || ((d == rt) && use_rt);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign IF_ID_rs = IF_ID_Instruction[25:21];
    assign IF_ID_rt = IF_ID_Instruction[20:16];

    // Register $0 is never a true dependency, so a zero source never requests a stall
    always_comb begin
        need_rs = IF_ID_valid & ID_UsesRs & (IF_ID_rs != 5'd0);
        need_rt = IF_ID_valid & ID_UsesRt & (IF_ID_rt != 5'd0);
        hx      = ID_EX_RegWrite & dest_match(ID_EX_Write_register, IF_ID_rs, IF_ID_rt,
                                              need_rs, need_rt);
        hm      = EX_MEM_MemRead & dest_match(EX_MEM_Write_register, IF_ID_rs, IF_ID_rt,
                                              need_rs, need_rt);
        need2   = (state == RUN) & ID_IsBranchOrJr & ID_EX_MemRead & hx;
        need1   = (state == RUN) & ~need2 &
                  ((ID_EX_MemRead & hx) | (ID_IsBranchOrJr & (hx | hm)));
        stall_active = (state == STALL) | need1 | need2;
        flush        = ~stall_active & IF_ID_valid & (ID_Branch_taken | ID_Jump);
        PC_Write     = ~stall_active;
        ID_EX_Bubble = stall_active;
    end

    // A branch consuming a load result in EX needs one extra cycle tracked by STALL
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            remaining <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (need2) begin
                        state     <= STALL;
                        remaining <= 1'b1;
                    end
                end
                STALL: begin
                    remaining <= remaining - 1'b1;
                    if (remaining == 1'b1)
                        state <= RUN;
                end
                default: begin
                    state     <= RUN;
                    remaining <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            IF_ID_Instruction <= NOP;
            IF_ID_PC_plus4    <= {DATA_W{1'b0}};
            IF_ID_valid       <= 1'b0;
        end else if (stall_active) begin
            IF_ID_Instruction <= IF_ID_Instruction;
            IF_ID_PC_plus4    <= IF_ID_PC_plus4;
            IF_ID_valid       <= IF_ID_valid;
        end else if (flush) begin
            IF_ID_Instruction <= NOP;
            IF_ID_PC_plus4    <= {DATA_W{1'b0}};
            IF_ID_valid       <= 1'b0;
        end else begin
            IF_ID_Instruction <= IF_Instruction;
            IF_ID_PC_plus4    <= IF_PC_plus4;
            IF_ID_valid       <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cycles <= {CNT_W{1'b0}};
        else if (stall_active)
            stall_cycles <= sat_inc(stall_cycles);
    end

endmodule
